// File: rtl/bcd_seg_scanner_if.sv
// Display-side bus of bcd_seg_scanner.
// Signalling: there is no valid/ready pair on this bus. 'finish' is a level
// from the multiplier and only its 0->1 transition means "new product on
// 'bcd'". 'bcd' is sampled in the cycle that transition is seen. 'valid' is a
// sticky level meaning "a product has been captured since reset". an/seg are
// free-running display drives, active-low.
interface bcd_seg_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  finish;
  logic [DIGITS*4-1:0]   bcd;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  valid;

  // Producer side: multiplier plus the display pins it observes.
  modport master (
    output finish,
    output bcd,
    input  an,
    input  seg,
    input  valid
  );

  // Scanner side.
  modport slave (
    input  finish,
    input  bcd,
    output an,
    output seg,
    output valid
  );
endinterface

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: captures a packed BCD product on each rising edge of the
// multiplier's finish flag and scans it onto a multiplexed 7-segment display,
// one digit per REFRESH_DIV clocks. an/seg are registered, so they follow the
// scan index and captured value with a one-cycle lag.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank digits above the
// most-significant nonzero digit. Digit0 is never blanked.
module bcd_seg_scanner #(
  parameter int N           = 5,
  parameter int REFRESH_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  bcd_seg_scanner_if.slave  bus
);
  localparam int DIGITS = ((2 * N) / 3) + 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic                finish_dly_q, finish_dly_d;
  logic [DIGITS*4-1:0] bcd_q, bcd_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic                rise;
  logic [3:0]          nib;
  logic                blank;

  // Active-low segment pattern; any non-BCD nibble shows 'E'.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h06;
    endcase
    return s;
  endfunction

  // Select the nibble for the current scan position and decide leading-zero blanking.
  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib = bcd_q[i*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this digit and everything above it is zero (never digit0).
        blank = (i != 0) && ((bcd_q >> (4 * i)) == '0);
`else
        blank = 1'b0;
`endif
      end
    end
  end

  // Next-state: edge-detected capture, prescaled scan index and output registers.
  always_comb begin
    rise         = bus.finish & ~finish_dly_q;
    finish_dly_d = bus.finish;
    bcd_d        = bcd_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    an_d         = '1;
    seg_d        = SEG_BLANK;

    if (rise) begin
      bcd_d   = bus.bcd;
      valid_d = 1'b1;
    end

    // Scan advances independently of capture, so both can happen together.
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs reflect the current (pre-edge) index and captured value.
    if (valid_q) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = blank ? SEG_BLANK : seg_decode(nib);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      finish_dly_q <= 1'b0;
      bcd_q        <= '0;
      valid_q      <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
    end else begin
      finish_dly_q <= finish_dly_d;
      bcd_q        <= bcd_d;
      valid_q      <= valid_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Testbench for bcd_seg_scanner (N=5, REFRESH_DIV=4, DIGITS=4).
// Directed scenarios followed by randomized finish/bcd/reset traffic. A
// cycle-level reference model derives every expected output from the number
// of clocks since reset and the last captured product.
module tb_bcd_seg_scanner;
  localparam int D = 4;
  localparam int R = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic clk;
  logic reset;

  bcd_seg_scanner_if #(.DIGITS(D)) bus ();

  bcd_seg_scanner #(.N(5), .REFRESH_DIV(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected {valid, an, seg} after each posedge.
  logic [11:0] exp_q[$];

  logic        m_prev_fin;
  logic        m_val;
  logic [15:0] m_cap;
  int          m_ticks;

  function automatic logic [6:0] model_seg(input logic [15:0] v, input int d);
    int n;
    n = int'((v >> (4 * d)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0) return 7'h7F;
`endif
    if (n > 9) return 7'h06;
    return SEG_TAB[n];
  endfunction

  always @(posedge clk) begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int         pos;
    if (reset) begin
      m_prev_fin = 1'b0;
      m_val      = 1'b0;
      m_cap      = '0;
      m_ticks    = 0;
      exp_q.push_back({1'b0, 4'hF, 7'h7F});
    end else begin
      // Digit lit during the cycle just ended: one step per R clocks since reset.
      pos   = (m_ticks / R) % D;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      if (m_val) begin
        e_an[pos] = 1'b0;
        e_seg     = model_seg(m_cap, pos);
      end
      if (bus.finish && !m_prev_fin) begin
        m_cap = bus.bcd;
        m_val = 1'b1;
      end
      m_prev_fin = bus.finish;
      m_ticks    = (m_ticks + 1) % (R * D);
      exp_q.push_back({m_val, e_an, e_seg});
    end
  end

  // Scoreboard: compare DUT outputs to the model mid-cycle.
  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("sb_valid", {31'd0, bus.valid}, {31'd0, e[11]});
      check_val("sb_an",    {28'd0, bus.an},    {28'd0, e[10:7]});
      check_val("sb_seg",   {25'd0, bus.seg},   {25'd0, e[6:0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    wait_cycles(n);
    reset = 1'b0;
  endtask

  // finish low for a cycle, then rise with the given product.
  task automatic capture(input logic [15:0] v);
    bus.finish = 1'b0;
    wait_cycles(1);
    bus.bcd    = v;
    bus.finish = 1'b1;
  endtask

  // Watch one full scan and check each digit's segments and dwell time.
  task automatic expect_scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] seen [D];
    int         hits [D];
    logic [3:0] pat;
    for (int i = 0; i < D; i++) begin
      seen[i] = 7'h7F;
      hits[i] = 0;
    end
    for (int c = 0; c < D * R; c++) begin
      @(negedge clk);
      for (int i = 0; i < D; i++) begin
        pat    = 4'hF;
        pat[i] = 1'b0;
        if (bus.an == pat) begin
          seen[i] = bus.seg;
          hits[i]++;
        end
      end
    end
    check_val({tag, "_d0"}, {25'd0, seen[0]}, {25'd0, s0});
    check_val({tag, "_d1"}, {25'd0, seen[1]}, {25'd0, s1});
    check_val({tag, "_d2"}, {25'd0, seen[2]}, {25'd0, s2});
    check_val({tag, "_d3"}, {25'd0, seen[3]}, {25'd0, s3});
    for (int i = 0; i < D; i++) check_val({tag, "_dwell"}, hits[i], R);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    int          top;
    v   = '0;
    top = $urandom_range(0, D - 1);
    for (int i = 0; i <= top; i++) begin
      if ($urandom_range(0, 7) == 0) v[i*4 +: 4] = 4'($urandom_range(10, 15));
      else                           v[i*4 +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    bus.finish = 1'b0;
    bus.bcd    = '0;

    // 1. reset then idle: display stays blank.
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(20);
    check_val("idle_an",    {28'd0, bus.an},  32'hF);
    check_val("idle_seg",   {25'd0, bus.seg}, 32'h7F);
    check_val("idle_valid", {31'd0, bus.valid}, 32'd0);

    // 2. first capture: valid one cycle after the edge, display one cycle later.
    bus.bcd    = 16'h0780;
    bus.finish = 1'b1;
    wait_cycles(1);
    check_val("cap_valid", {31'd0, bus.valid}, 32'd1);
    check_val("cap_lag_an", {28'd0, bus.an}, 32'hF);
    wait_cycles(1);
    expect_scan("p0780", 7'h40, 7'h00, 7'h78, LZ);

    // 3. bcd changes while finish stays high are ignored; a new rise captures.
    bus.bcd = 16'h0169;
    wait_cycles(20);
    expect_scan("hold", 7'h40, 7'h00, 7'h78, LZ);
    capture(16'h0169);
    wait_cycles(2);
    expect_scan("p0169", 7'h10, 7'h02, 7'h79, LZ);

    // 4. non-BCD nibble decodes to 'E'.
    capture(16'h00A5);
    wait_cycles(2);
    expect_scan("p00A5", 7'h12, 7'h06, LZ, LZ);

    // 5. reset mid-scan with finish high; release recaptures.
    wait_cycles(5);
    reset   = 1'b1;
    bus.bcd = 16'h0321;
    wait_cycles(1);
    check_val("mid_rst_an",    {28'd0, bus.an},    32'hF);
    check_val("mid_rst_seg",   {25'd0, bus.seg},   32'h7F);
    check_val("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(2);
    expect_scan("p0321", 7'h79, 7'h24, 7'h30, LZ);

    // 6. product zero: digit0 always shows "0".
    capture(16'h0000);
    wait_cycles(2);
    expect_scan("p0000", 7'h40, LZ, LZ, LZ);

    // Randomized traffic, scoreboard-checked every cycle.
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0:       do_reset($urandom_range(1, 2));
        1, 2:    bus.bcd = rand_bcd();
        3, 4, 5: begin
          bus.bcd    = rand_bcd();
          bus.finish = ~bus.finish;
        end
        default: bus.finish = 1'($urandom_range(0, 1));
      endcase
      wait_cycles($urandom_range(1, 8));
    end

    wait_cycles(4);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
